// File: rtl/tiny16_pkg.sv
// Shared tiny16 core types: ALU operation/flag types, branch conditions,
// writeback entries and the writeback skid-buffer state.
package tiny16_pkg;

  localparam int TINY_DATA_W = 16;
  localparam int TINY_RD_W   = 3;

  typedef enum logic [3:0] {
    ALU_ADD,
    ALU_SUB,
    ALU_AND,
    ALU_OR,
    ALU_XOR,
    ALU_NOT,
    ALU_SHL,
    ALU_SHR,
    ALU_PASS
  } ALUOp;

  typedef struct packed {
    logic z;
    logic c;
    logic n;
    logic v;
  } ALUFlags;

  typedef enum logic [2:0] {
    COND_ALWAYS = 3'd0,
    COND_EQ     = 3'd1,
    COND_NE     = 3'd2,
    COND_CS     = 3'd3,
    COND_CC     = 3'd4,
    COND_MI     = 3'd5,
    COND_VS     = 3'd6,
    COND_LT     = 3'd7
  } BranchCond;

  typedef struct packed {
    logic [TINY_DATA_W-1:0] data;
    logic [TINY_RD_W-1:0]   rd;
  } WbEntry;

  typedef enum logic [1:0] {
    BUF_EMPTY,
    BUF_ONE,
    BUF_FULL
  } BufState;

  function automatic logic cond_met(input BranchCond cond, input ALUFlags f);
    logic met;
    met = 1'b0;
    case (cond)
      COND_ALWAYS: met = 1'b1;
      COND_EQ:     met = f.z;
      COND_NE:     met = ~f.z;
      COND_CS:     met = f.c;
      COND_CC:     met = ~f.c;
      COND_MI:     met = f.n;
      COND_VS:     met = f.v;
      COND_LT:     met = f.n ^ f.v;
      default:     met = 1'b0;
    endcase
    return met;
  endfunction

endpackage

// File: rtl/skid_buffer.sv
// Two-entry (main + skid) valid/ready buffer with a registered push_ready,
// so the upstream ready never depends combinationally on pop_ready.
module skid_buffer
  import tiny16_pkg::*;
#(
  parameter int WIDTH = $bits(WbEntry)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             flush,
  input  logic             push_valid,
  output logic             push_ready,
  input  logic [WIDTH-1:0] push_data,
  output logic             pop_valid,
  input  logic             pop_ready,
  output logic [WIDTH-1:0] pop_data
);

  BufState          state;
  BufState          state_next;
  logic [WIDTH-1:0] main_q;
  logic [WIDTH-1:0] skid_q;
  logic             ready_q;
  logic             push;
  logic             pop;

  assign push = push_valid & ready_q & ~flush;
  assign pop  = pop_valid & pop_ready;

  // ready_q mirrors "not full" one cycle ahead so it is a plain flop output.
  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= BUF_EMPTY;
      ready_q <= 1'b1;
    end else begin
      state   <= state_next;
      ready_q <= (state_next != BUF_FULL);
    end
  end

  always_comb begin
    state_next = state;
    if (flush) begin
      state_next = BUF_EMPTY;
    end else begin
      case (state)
        BUF_EMPTY: begin
          if (push) state_next = BUF_ONE;
        end
        BUF_ONE: begin
          if (push && !pop)      state_next = BUF_FULL;
          else if (!push && pop) state_next = BUF_EMPTY;
        end
        BUF_FULL: begin
          if (pop) state_next = BUF_ONE;
        end
        default: state_next = BUF_EMPTY;
      endcase
    end
  end

  always_comb begin
    pop_valid  = (state != BUF_EMPTY);
    push_ready = ready_q;
    pop_data   = main_q;
  end

  // main_q only changes when the head is consumed or the buffer was empty,
  // keeping the head stable while stalled.
  always_ff @(posedge clk) begin
    if (rst) begin
      main_q <= '0;
      skid_q <= '0;
    end else if (!flush) begin
      case (state)
        BUF_EMPTY: begin
          if (push) main_q <= push_data;
        end
        BUF_ONE: begin
          if (push) begin
            if (pop) main_q <= push_data;
            else     skid_q <= push_data;
          end
        end
        BUF_FULL: begin
          if (pop) main_q <= skid_q;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: rtl/ex_wb_stage.sv
// Execute/writeback stage: architectural flag register, conditional branch
// resolution and a skid-buffered path to register-file writeback.
module ex_wb_stage
  import tiny16_pkg::*;
#(
  parameter int DATA_W = TINY_DATA_W,
  parameter int RD_W   = TINY_RD_W
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_d,
  input  logic [3:0]        in_flags,
  input  logic              in_flags_en,
  input  logic [RD_W-1:0]   in_rd,
  input  logic              in_wb_en,
  input  logic              in_is_branch,
  input  logic [2:0]        in_cond,
  input  logic [DATA_W-1:0] in_target,
  input  logic              flush,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_data,
  output logic [RD_W-1:0]   out_rd,
  output logic              out_wb_en,
  output logic [3:0]        flags_q,
  output logic              br_taken,
  output logic [DATA_W-1:0] br_target
);

  ALUFlags           flags_r;
  logic              br_taken_r;
  logic [DATA_W-1:0] br_target_r;
  logic              buf_ready;
  logic              buf_valid;
  logic              accept;
  logic              enq;
  WbEntry            enq_entry;
  WbEntry            head_entry;

  // Every entry, including branches and no-writeback entries, is gated by the
  // buffer's ready so acceptance stays a single registered condition.
  assign accept    = in_valid & buf_ready & ~flush;
  assign enq       = accept & ~in_is_branch & in_wb_en;
  assign enq_entry = '{data: in_d, rd: in_rd};

  skid_buffer #(
    .WIDTH($bits(WbEntry))
  ) u_skid (
    .clk        (clk),
    .rst        (rst),
    .flush      (flush),
    .push_valid (enq),
    .push_ready (buf_ready),
    .push_data  (enq_entry),
    .pop_valid  (buf_valid),
    .pop_ready  (out_ready),
    .pop_data   (head_entry)
  );

  // The branch reads flags_r before this edge, so an immediately preceding
  // flag-setting entry is already visible to it.
  always_ff @(posedge clk) begin
    if (rst) begin
      flags_r     <= '0;
      br_taken_r  <= 1'b0;
      br_target_r <= '0;
    end else begin
      br_taken_r <= accept & in_is_branch & cond_met(BranchCond'(in_cond), flags_r);
      if (accept && in_is_branch) begin
        br_target_r <= in_target;
      end
      if (accept && !in_is_branch && in_flags_en) begin
        flags_r <= ALUFlags'(in_flags);
      end
    end
  end

  always_comb begin
    in_ready  = buf_ready;
    out_valid = buf_valid;
    out_data  = head_entry.data;
    out_rd    = head_entry.rd;
    out_wb_en = buf_valid;
    flags_q   = flags_r;
    br_taken  = br_taken_r;
    br_target = br_target_r;
  end

endmodule

// File: tb/tb_ex_wb_stage.sv
// Self-checking bench for ex_wb_stage: directed vector table plus random
// traffic compared against a queue-based reference model.
module tb_ex_wb_stage;

  logic        clk;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [15:0] in_d;
  logic [3:0]  in_flags;
  logic        in_flags_en;
  logic [2:0]  in_rd;
  logic        in_wb_en;
  logic        in_is_branch;
  logic [2:0]  in_cond;
  logic [15:0] in_target;
  logic        flush;
  logic        out_valid;
  logic        out_ready;
  logic [15:0] out_data;
  logic [2:0]  out_rd;
  logic        out_wb_en;
  logic [3:0]  flags_q;
  logic        br_taken;
  logic [15:0] br_target;

  int total = 0;
  int bad   = 0;

  typedef struct {
    logic        rst;
    logic        vld;
    logic [15:0] d;
    logic [3:0]  fl;
    logic        fen;
    logic [2:0]  rd;
    logic        wen;
    logic        br;
    logic [2:0]  cond;
    logic [15:0] tgt;
    logic        flush;
    logic        ordy;
  } stim_t;

  typedef struct {
    stim_t       s;
    logic        ov;
    logic [15:0] od;
    logic [2:0]  ord;
    logic        ir;
    logic [3:0]  fl;
    logic        bt;
    logic [15:0] btg;
  } vec_t;

  vec_t vecs[$];

  // Reference model: a FIFO of at most two {data, rd} entries.
  logic [18:0] m_q[$];
  logic [3:0]  m_flags;
  logic        m_bt;
  logic [15:0] m_btg;
  logic        m_ready;

  ex_wb_stage dut (
    .clk          (clk),
    .rst          (rst),
    .in_valid     (in_valid),
    .in_ready     (in_ready),
    .in_d         (in_d),
    .in_flags     (in_flags),
    .in_flags_en  (in_flags_en),
    .in_rd        (in_rd),
    .in_wb_en     (in_wb_en),
    .in_is_branch (in_is_branch),
    .in_cond      (in_cond),
    .in_target    (in_target),
    .flush        (flush),
    .out_valid    (out_valid),
    .out_ready    (out_ready),
    .out_data     (out_data),
    .out_rd       (out_rd),
    .out_wb_en    (out_wb_en),
    .flags_q      (flags_q),
    .br_taken     (br_taken),
    .br_target    (br_target)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  function automatic vec_t row(
    input logic rst_i, input logic vld, input logic [15:0] d, input logic [3:0] fl,
    input logic fen, input logic [2:0] rd, input logic wen, input logic br,
    input logic [2:0] cond, input logic [15:0] tgt, input logic fl_sh, input logic ordy,
    input logic ov, input logic [15:0] od, input logic [2:0] ord, input logic ir,
    input logic [3:0] efl, input logic bt, input logic [15:0] btg);
    vec_t v;
    v.s.rst = rst_i; v.s.vld = vld; v.s.d = d; v.s.fl = fl; v.s.fen = fen;
    v.s.rd = rd; v.s.wen = wen; v.s.br = br; v.s.cond = cond; v.s.tgt = tgt;
    v.s.flush = fl_sh; v.s.ordy = ordy;
    v.ov = ov; v.od = od; v.ord = ord; v.ir = ir; v.fl = efl; v.bt = bt; v.btg = btg;
    return v;
  endfunction

  function automatic logic modelCond(input logic [2:0] c, input logic [3:0] f);
    logic z, cy, n, v, r;
    z = f[3]; cy = f[2]; n = f[1]; v = f[0];
    r = 1'b0;
    case (c)
      3'd0: r = 1'b1;
      3'd1: r = z;
      3'd2: r = !z;
      3'd3: r = cy;
      3'd4: r = !cy;
      3'd5: r = n;
      3'd6: r = v;
      3'd7: r = (n != v);
      default: r = 1'b0;
    endcase
    return r;
  endfunction

  task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("[TB] FAIL %s got=%h expected=%h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic modelStep(input stim_t s);
    logic acc, pop;
    if (s.rst) begin
      m_q.delete();
      m_flags = 4'b0;
      m_bt    = 1'b0;
      m_btg   = 16'h0;
      m_ready = 1'b1;
    end else begin
      acc = s.vld && m_ready && !s.flush;
      pop = (m_q.size() > 0) && s.ordy;
      if (s.flush) begin
        m_q.delete();
      end else begin
        if (pop) void'(m_q.pop_front());
        if (acc && !s.br && s.wen) m_q.push_back({s.d, s.rd});
      end
      m_bt = acc && s.br && modelCond(s.cond, m_flags);
      if (acc && s.br) m_btg = s.tgt;
      if (acc && !s.br && s.fen) m_flags = s.fl;
      m_ready = (m_q.size() < 2);
    end
  endtask

  task automatic applyStimulus(input stim_t s);
    rst          = s.rst;
    in_valid     = s.vld;
    in_d         = s.d;
    in_flags     = s.fl;
    in_flags_en  = s.fen;
    in_rd        = s.rd;
    in_wb_en     = s.wen;
    in_is_branch = s.br;
    in_cond      = s.cond;
    in_target    = s.tgt;
    flush        = s.flush;
    out_ready    = s.ordy;
    modelStep(s);
    @(posedge clk);
    #1;
  endtask

  task automatic checkOutput(input string tag);
    logic [18:0] head;
    check({tag, ".in_ready"},  16'(in_ready),  16'(m_ready));
    check({tag, ".out_valid"}, 16'(out_valid), 16'(m_q.size() > 0));
    check({tag, ".flags_q"},   16'(flags_q),   16'(m_flags));
    check({tag, ".br_taken"},  16'(br_taken),  16'(m_bt));
    if (m_q.size() > 0) begin
      head = m_q[0];
      check({tag, ".out_data"},  out_data,        head[18:3]);
      check({tag, ".out_rd"},    16'(out_rd),     16'(head[2:0]));
      check({tag, ".out_wb_en"}, 16'(out_wb_en),  16'h1);
    end
    if (m_bt) check({tag, ".br_target"}, br_target, m_btg);
  endtask

  task automatic checkVector(input int i);
    string tag;
    tag = $sformatf("vec%0d", i);
    check({tag, ".out_valid"}, 16'(out_valid), 16'(vecs[i].ov));
    check({tag, ".in_ready"},  16'(in_ready),  16'(vecs[i].ir));
    check({tag, ".flags_q"},   16'(flags_q),   16'(vecs[i].fl));
    check({tag, ".br_taken"},  16'(br_taken),  16'(vecs[i].bt));
    if (vecs[i].ov || vecs[i].s.rst) begin
      check({tag, ".out_data"}, out_data,     vecs[i].od);
      check({tag, ".out_rd"},   16'(out_rd),  16'(vecs[i].ord));
    end
    if (vecs[i].bt || vecs[i].s.rst) check({tag, ".br_target"}, br_target, vecs[i].btg);
  endtask

  initial begin
    stim_t s;
    //             rst vld d        fl       fen rd wen br cond tgt      fsh ordy | ov od       ord ir fl       bt btg
    vecs.push_back(row(1, 0, 16'h0000, 4'b0000, 0, 0, 0, 0, 0, 16'h0000, 0, 1,  0, 16'h0000, 0, 1, 4'b0000, 0, 16'h0000));
    vecs.push_back(row(0, 1, 16'h1234, 4'b0100, 1, 3, 1, 0, 0, 16'h0000, 0, 1,  1, 16'h1234, 3, 1, 4'b0100, 0, 16'h0000));
    vecs.push_back(row(0, 0, 16'h0000, 4'b0000, 0, 0, 0, 0, 0, 16'h0000, 0, 1,  0, 16'h0000, 0, 1, 4'b0100, 0, 16'h0000));
    vecs.push_back(row(0, 1, 16'h0000, 4'b1000, 1, 1, 1, 0, 0, 16'h0000, 0, 1,  1, 16'h0000, 1, 1, 4'b1000, 0, 16'h0000));
    vecs.push_back(row(0, 1, 16'h0000, 4'b0000, 1, 2, 1, 1, 1, 16'h0040, 0, 1,  0, 16'h0000, 0, 1, 4'b1000, 1, 16'h0040));
    vecs.push_back(row(0, 1, 16'h0000, 4'b0000, 0, 0, 0, 1, 2, 16'h0080, 0, 1,  0, 16'h0000, 0, 1, 4'b1000, 0, 16'h0000));
    vecs.push_back(row(0, 0, 16'h0000, 4'b0000, 0, 0, 0, 0, 0, 16'h0000, 0, 1,  0, 16'h0000, 0, 1, 4'b1000, 0, 16'h0000));
    vecs.push_back(row(0, 1, 16'h0001, 4'b0000, 0, 1, 1, 0, 0, 16'h0000, 0, 0,  1, 16'h0001, 1, 1, 4'b1000, 0, 16'h0000));
    vecs.push_back(row(0, 1, 16'h0002, 4'b0000, 0, 2, 1, 0, 0, 16'h0000, 0, 0,  1, 16'h0001, 1, 0, 4'b1000, 0, 16'h0000));
    vecs.push_back(row(0, 1, 16'h0003, 4'b0000, 0, 3, 1, 0, 0, 16'h0000, 0, 0,  1, 16'h0001, 1, 0, 4'b1000, 0, 16'h0000));
    vecs.push_back(row(0, 1, 16'h0003, 4'b0000, 0, 3, 1, 0, 0, 16'h0000, 0, 1,  1, 16'h0002, 2, 1, 4'b1000, 0, 16'h0000));
    vecs.push_back(row(0, 1, 16'h0003, 4'b0000, 0, 3, 1, 0, 0, 16'h0000, 0, 1,  1, 16'h0003, 3, 1, 4'b1000, 0, 16'h0000));
    vecs.push_back(row(0, 0, 16'h0000, 4'b0000, 0, 0, 0, 0, 0, 16'h0000, 0, 1,  0, 16'h0000, 0, 1, 4'b1000, 0, 16'h0000));
    vecs.push_back(row(0, 1, 16'h000A, 4'b0000, 0, 2, 1, 0, 0, 16'h0000, 0, 0,  1, 16'h000A, 2, 1, 4'b1000, 0, 16'h0000));
    vecs.push_back(row(0, 1, 16'h000B, 4'b0000, 0, 2, 1, 0, 0, 16'h0000, 0, 0,  1, 16'h000A, 2, 0, 4'b1000, 0, 16'h0000));
    vecs.push_back(row(0, 1, 16'h000C, 4'b1111, 1, 2, 1, 0, 0, 16'h0000, 1, 0,  0, 16'h0000, 0, 1, 4'b1000, 0, 16'h0000));
    vecs.push_back(row(0, 1, 16'h000D, 4'b1111, 1, 2, 1, 0, 0, 16'h0000, 1, 0,  0, 16'h0000, 0, 1, 4'b1000, 0, 16'h0000));
    vecs.push_back(row(0, 1, 16'h0009, 4'b0000, 1, 0, 0, 0, 0, 16'h0000, 0, 1,  0, 16'h0000, 0, 1, 4'b0000, 0, 16'h0000));
    vecs.push_back(row(0, 1, 16'h0007, 4'b1111, 1, 4, 1, 1, 0, 16'h1111, 0, 1,  0, 16'h0000, 0, 1, 4'b0000, 1, 16'h1111));
    vecs.push_back(row(0, 1, 16'h0005, 4'b0011, 1, 5, 0, 0, 0, 16'h0000, 0, 1,  0, 16'h0000, 0, 1, 4'b0011, 0, 16'h0000));
    vecs.push_back(row(0, 1, 16'h0000, 4'b0000, 0, 0, 0, 1, 7, 16'h0100, 0, 1,  0, 16'h0000, 0, 1, 4'b0011, 0, 16'h0000));
    vecs.push_back(row(0, 1, 16'h0000, 4'b0000, 0, 0, 0, 1, 6, 16'h0200, 0, 1,  0, 16'h0000, 0, 1, 4'b0011, 1, 16'h0200));
    vecs.push_back(row(0, 1, 16'h0021, 4'b0000, 0, 4, 1, 0, 0, 16'h0000, 0, 0,  1, 16'h0021, 4, 1, 4'b0011, 0, 16'h0000));
    vecs.push_back(row(0, 1, 16'h0000, 4'b0000, 0, 0, 0, 1, 0, 16'h0300, 0, 0,  1, 16'h0021, 4, 1, 4'b0011, 1, 16'h0300));
    vecs.push_back(row(1, 1, 16'h0022, 4'b0000, 0, 4, 1, 0, 0, 16'h0000, 0, 0,  0, 16'h0000, 0, 1, 4'b0000, 0, 16'h0000));
    vecs.push_back(row(0, 1, 16'h0031, 4'b1010, 1, 5, 1, 0, 0, 16'h0000, 0, 0,  1, 16'h0031, 5, 1, 4'b1010, 0, 16'h0000));
    vecs.push_back(row(0, 1, 16'h0032, 4'b0000, 0, 6, 1, 0, 0, 16'h0000, 0, 0,  1, 16'h0031, 5, 0, 4'b1010, 0, 16'h0000));
    vecs.push_back(row(1, 0, 16'h0000, 4'b0000, 0, 0, 0, 0, 0, 16'h0000, 0, 0,  0, 16'h0000, 0, 1, 4'b0000, 0, 16'h0000));
    vecs.push_back(row(0, 0, 16'h0000, 4'b0000, 0, 0, 0, 0, 0, 16'h0000, 0, 1,  0, 16'h0000, 0, 1, 4'b0000, 0, 16'h0000));

    $display("[TB] directed vectors: %0d", vecs.size());
    for (int i = 0; i < vecs.size(); i++) begin
      applyStimulus(vecs[i].s);
      checkOutput("dir");
      checkVector(i);
    end

    $display("[TB] random traffic");
    for (int n = 0; n < 2000; n++) begin
      s.rst   = ($urandom_range(0, 199) == 0);
      s.vld   = ($urandom_range(0, 3) != 0);
      s.d     = 16'($urandom);
      s.fl    = 4'($urandom);
      s.fen   = 1'($urandom);
      s.rd    = 3'($urandom);
      s.wen   = ($urandom_range(0, 3) != 0);
      s.br    = ($urandom_range(0, 4) == 0);
      s.cond  = 3'($urandom);
      s.tgt   = 16'($urandom);
      s.flush = ($urandom_range(0, 29) == 0);
      s.ordy  = ($urandom_range(0, 2) != 0);
      applyStimulus(s);
      checkOutput("rand");
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
